// File: rtl/rgmii_rx_idelay_cal.sv
// RGMII receive IDELAY calibration: sweeps all 32 taps and scores preamble/SFD integrity at each one.
// It then loads the centre of the longest run of passing taps, or IDELAY_DEFAULT if no run is long enough.
module rgmii_rx_idelay_cal #(
   parameter int unsigned IDELAY_DEFAULT = 0,
   parameter int unsigned SETTLE_CYC     = 16,
   parameter int unsigned FRAMES_PER_TAP = 4,
   parameter int unsigned TIMEOUT_CYC    = 1000000,
   parameter int unsigned MIN_WIN        = 3
) (
   input  logic       gmii_rx_clk,
   input  logic       rst,
   input  logic       cal_start,
   input  logic       gmii_rx_dv,
   input  logic [7:0] gmii_rxd,
   output logic [4:0] idelay_cntvalue,
   output logic       idelay_ld,
   output logic       cal_busy,
   output logic       cal_done,
   output logic       cal_fail,
   output logic [4:0] win_lo,
   output logic [4:0] win_hi
);

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
   localparam logic [7:0]       FPT      = 8'(FRAMES_PER_TAP);
   localparam logic [5:0]       MIN_LEN  = 6'(MIN_WIN);
   localparam logic [4:0]       DEF_TAP  = 5'(IDELAY_DEFAULT);
   localparam logic [7:0]       PRE_BYTE = 8'h55;
   localparam logic [7:0]       SFD_BYTE = 8'hD5;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SETTLE, S_OBSERVE, S_EVAL, S_FINAL, S_DONE
   } state_t;

   state_t           state_reg, state_next;
   logic [4:0]       tap_reg, tap_next;
   logic [SET_W-1:0] settle_cnt_reg, settle_cnt_next;
   logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
   logic [7:0]       frames_reg, frames_next;
   logic [7:0]       bad_reg, bad_next;
   logic             armed_reg, armed_next;
   logic             in_frame_reg, in_frame_next;
   logic [2:0]       byte_idx_reg, byte_idx_next;
   logic             err_reg, err_next;
   logic             prev_dv_reg;
   logic [4:0]       run_lo_reg, run_lo_next;
   logic [5:0]       run_len_reg, run_len_next;
   logic [4:0]       best_lo_reg, best_lo_next;
   logic [5:0]       best_len_reg, best_len_next;
   logic [4:0]       cntvalue_reg, cntvalue_next;
   logic             ld_reg, ld_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;
   logic             fail_reg, fail_next;
   logic [4:0]       win_lo_reg, win_lo_next;
   logic [4:0]       win_hi_reg, win_hi_next;

   logic             tap_pass;
   logic [5:0]       run_len_inc;
   logic [5:0]       centre_off;
   logic [5:0]       hi_sum;

   always_comb begin
      state_next      = state_reg;
      tap_next        = tap_reg;
      settle_cnt_next = settle_cnt_reg;
      tmo_cnt_next    = tmo_cnt_reg;
      frames_next     = frames_reg;
      bad_next        = bad_reg;
      armed_next      = armed_reg;
      in_frame_next   = in_frame_reg;
      byte_idx_next   = byte_idx_reg;
      err_next        = err_reg;
      run_lo_next     = run_lo_reg;
      run_len_next    = run_len_reg;
      best_lo_next    = best_lo_reg;
      best_len_next   = best_len_reg;
      cntvalue_next   = cntvalue_reg;
      ld_next         = 1'b0;
      busy_next       = busy_reg;
      done_next       = done_reg;
      fail_next       = fail_reg;
      win_lo_next     = win_lo_reg;
      win_hi_next     = win_hi_reg;
      tap_pass        = (frames_reg != 8'd0) && (bad_reg == 8'd0);
      run_len_inc     = run_len_reg + 6'd1;
      centre_off      = (best_len_reg - 6'd1) >> 1;
      hi_sum          = {1'b0, best_lo_reg} + best_len_reg - 6'd1;

      case (state_reg)
         S_IDLE: begin
            if (cal_start) begin
               done_next     = 1'b0;
               fail_next     = 1'b0;
               busy_next     = 1'b1;
               run_lo_next   = 5'd0;
               run_len_next  = 6'd0;
               best_lo_next  = 5'd0;
               best_len_next = 6'd0;
               tap_next      = 5'd0;
               state_next    = S_LOAD;
            end
         end
         S_LOAD: begin
            cntvalue_next   = tap_reg;
            ld_next         = 1'b1;
            settle_cnt_next = '0;
            state_next      = S_SETTLE;
         end
         S_SETTLE: begin
            if (settle_cnt_reg == SET_LAST) begin
               tmo_cnt_next  = '0;
               frames_next   = 8'd0;
               bad_next      = 8'd0;
               armed_next    = 1'b0;
               in_frame_next = 1'b0;
               state_next    = S_OBSERVE;
            end else begin
               settle_cnt_next = settle_cnt_reg + 1'b1;
            end
         end
         S_OBSERVE: begin
            // A frame already running at entry must not be scored mid-way, so arm only after dv is seen low.
            if (!gmii_rx_dv)
               armed_next = 1'b1;
            if (in_frame_reg) begin
               if (!gmii_rx_dv) begin
                  in_frame_next = 1'b0;
                  frames_next   = frames_reg + 8'd1;
                  bad_next      = bad_reg + 8'd1;
               end else if (byte_idx_reg == 3'd7) begin
                  in_frame_next = 1'b0;
                  frames_next   = frames_reg + 8'd1;
                  if (err_reg || (gmii_rxd != SFD_BYTE))
                     bad_next = bad_reg + 8'd1;
               end else begin
                  byte_idx_next = byte_idx_reg + 3'd1;
                  if (gmii_rxd != PRE_BYTE)
                     err_next = 1'b1;
               end
            end else if (armed_reg && gmii_rx_dv && !prev_dv_reg) begin
               in_frame_next = 1'b1;
               byte_idx_next = 3'd1;
               err_next      = (gmii_rxd != PRE_BYTE);
            end
            tmo_cnt_next = tmo_cnt_reg + 1'b1;
            if ((frames_next >= FPT) || (tmo_cnt_reg == TMO_LAST))
               state_next = S_EVAL;
         end
         S_EVAL: begin
            if (tap_pass) begin
               run_len_next = run_len_inc;
               if (run_len_reg == 6'd0)
                  run_lo_next = tap_reg;
               // Strict compare keeps the earliest window when two are equally long.
               if (run_len_inc > best_len_reg) begin
                  best_lo_next  = (run_len_reg == 6'd0) ? tap_reg : run_lo_reg;
                  best_len_next = run_len_inc;
               end
            end else begin
               run_len_next = 6'd0;
            end
            if (tap_reg == 5'd31) begin
               state_next = S_FINAL;
            end else begin
               tap_next   = tap_reg + 5'd1;
               state_next = S_LOAD;
            end
         end
         S_FINAL: begin
            if (best_len_reg >= MIN_LEN) begin
               cntvalue_next = best_lo_reg + centre_off[4:0];
            end else begin
               cntvalue_next = DEF_TAP;
               fail_next     = 1'b1;
            end
            ld_next     = 1'b1;
            win_lo_next = best_lo_reg;
            win_hi_next = hi_sum[4:0];
            done_next   = 1'b1;
            busy_next   = 1'b0;
            state_next  = S_DONE;
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge gmii_rx_clk) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         tap_reg        <= 5'd0;
         settle_cnt_reg <= '0;
         tmo_cnt_reg    <= '0;
         frames_reg     <= 8'd0;
         bad_reg        <= 8'd0;
         armed_reg      <= 1'b0;
         in_frame_reg   <= 1'b0;
         byte_idx_reg   <= 3'd0;
         err_reg        <= 1'b0;
         prev_dv_reg    <= 1'b0;
         run_lo_reg     <= 5'd0;
         run_len_reg    <= 6'd0;
         best_lo_reg    <= 5'd0;
         best_len_reg   <= 6'd0;
         cntvalue_reg   <= DEF_TAP;
         ld_reg         <= 1'b0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         fail_reg       <= 1'b0;
         win_lo_reg     <= 5'd0;
         win_hi_reg     <= 5'd0;
      end else begin
         state_reg      <= state_next;
         tap_reg        <= tap_next;
         settle_cnt_reg <= settle_cnt_next;
         tmo_cnt_reg    <= tmo_cnt_next;
         frames_reg     <= frames_next;
         bad_reg        <= bad_next;
         armed_reg      <= armed_next;
         in_frame_reg   <= in_frame_next;
         byte_idx_reg   <= byte_idx_next;
         err_reg        <= err_next;
         prev_dv_reg    <= gmii_rx_dv;
         run_lo_reg     <= run_lo_next;
         run_len_reg    <= run_len_next;
         best_lo_reg    <= best_lo_next;
         best_len_reg   <= best_len_next;
         cntvalue_reg   <= cntvalue_next;
         ld_reg         <= ld_next;
         busy_reg       <= busy_next;
         done_reg       <= done_next;
         fail_reg       <= fail_next;
         win_lo_reg     <= win_lo_next;
         win_hi_reg     <= win_hi_next;
      end
   end

   assign idelay_cntvalue = cntvalue_reg;
   assign idelay_ld       = ld_reg;
   assign cal_busy        = busy_reg;
   assign cal_done        = done_reg;
   assign cal_fail        = fail_reg;
   assign win_lo          = win_lo_reg;
   assign win_hi          = win_hi_reg;

endmodule
